accum_array: RTL and testbench

- Word-count accumulation memory that sits directly downstream of the search-and-add controller.
- Consumes its (accum_addr, accum_din, accum_we) update stream and adds accum_din into a counter RAM at accum_addr using a pipelined read-modify-write.
- On request, zero-fills the RAM, or streams the first rd_num counters out over AXI-Stream to the AXI write master for host readback.

---
 rtl/accum_array.sv | 148 ++++++++++++++
 tb/tb_accum_array.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/accum_array.sv
// accum_array: word-count accumulation RAM with pipelined read-modify-write, zero-fill and AXI-Stream readout
//   clk, reset                        : clock, asynchronous active-low reset
//   accum_addr, accum_din, accum_we   : update stream, adds accum_din into counter accum_addr
//   clear_kick                        : zero all counters and clear error
//   rd_kick, rd_num                   : stream out counters 0..min(rd_num, DEPTH)-1
//   busy, error                       : not idle, sticky dropped-update flag
//   m_axis_tvalid/tready/tdata/tlast  : readout stream
module accum_array #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] accum_addr,
    input  logic [63:0] accum_din,
    input  logic        accum_we,
    input  logic        clear_kick,
    input  logic        rd_kick,
    input  logic [31:0] rd_num,
    output logic        busy,
    output logic        error,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic        m_axis_tlast
);
    localparam int CW = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {INIT_CLEAR, CLEAR, IDLE, DRAIN, READ, FLUSH} state_t;
    state_t state, state_n;

    logic [63:0]           mem [DEPTH];
    logic [63:0]           ram_q, ram_wd;
    logic [ADDR_WIDTH-1:0] ram_wa, ram_ra;
    logic                  ram_we;

    logic [ADDR_WIDTH-1:0] clr_idx;
    logic                  drain_cnt, kick_clr;
    logic                  s0_v, s1_v, fwd_hit;
    logic [ADDR_WIDTH-1:0] s0_addr, s1_addr;
    logic [63:0]           s0_din, s1_din, fwd_sum, sum;
    logic [CW-1:0]         rd_idx, rd_n;
    logic                  rd_pend, pend_last, issue, push, pop;
    logic [63:0]           fifo_d [2];
    logic [1:0]            fifo_l;
    logic                  wp, rp;
    logic [1:0]            cnt, occ;
    logic                  clearing, in_range, accept, kick;

    assign clearing = state == INIT_CLEAR || state == CLEAR;
    assign in_range = accum_addr < 32'(DEPTH);
    assign accept   = accum_we && state == IDLE && in_range;
    assign kick     = state == IDLE && (clear_kick || rd_kick);

    // The RAM read for the update in s0 misses a write retiring from s1 in the
    // same cycle; that sum is captured and substituted one cycle later.
    assign sum = (fwd_hit ? fwd_sum : ram_q) + s1_din;

    // Space is judged against the FIFO occupancy including the read in flight,
    // so a stall can never overflow the two entries.
    assign pop   = m_axis_tvalid && m_axis_tready;
    assign push  = rd_pend;
    assign occ   = cnt + {1'b0, rd_pend} - {1'b0, pop};
    assign issue = state == READ && rd_idx < rd_n && occ < 2'd2;

    assign ram_we = clearing || s1_v;
    assign ram_wa = clearing ? clr_idx : s1_addr;
    assign ram_wd = clearing ? '0 : sum;
    assign ram_ra = state == READ ? rd_idx[ADDR_WIDTH-1:0] : s0_addr;

    assign busy          = state != IDLE;
    assign m_axis_tvalid = cnt != 2'd0;
    assign m_axis_tdata  = fifo_d[rp];
    assign m_axis_tlast  = m_axis_tvalid && fifo_l[rp];

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_wd;
        ram_q <= mem[ram_ra];
    end

    always_comb begin
        state_n = state;
        case (state)
            INIT_CLEAR, CLEAR: state_n = clr_idx == ADDR_WIDTH'(DEPTH - 1) ? IDLE : state;
            IDLE:              state_n = kick ? DRAIN : IDLE;
            DRAIN:             state_n = !drain_cnt ? DRAIN : kick_clr ? CLEAR : READ;
            READ:              state_n = rd_idx == rd_n ? FLUSH : READ;
            FLUSH:             state_n = cnt == 2'd0 && !rd_pend ? IDLE : FLUSH;
            default:           state_n = INIT_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT_CLEAR;
            clr_idx   <= '0;
            drain_cnt <= 1'b0;
            kick_clr  <= 1'b0;
            error     <= 1'b0;
            s0_v      <= 1'b0;
            s1_v      <= 1'b0;
            fwd_hit   <= 1'b0;
            s0_addr   <= '0;
            s1_addr   <= '0;
            s0_din    <= '0;
            s1_din    <= '0;
            fwd_sum   <= '0;
            rd_idx    <= '0;
            rd_n      <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
            fifo_d[0] <= '0;
            fifo_d[1] <= '0;
            fifo_l    <= '0;
            wp        <= 1'b0;
            rp        <= 1'b0;
            cnt       <= '0;
        end else begin
            state     <= state_n;
            clr_idx   <= clearing ? clr_idx + ADDR_WIDTH'(1) : clr_idx;
            drain_cnt <= state == DRAIN && !drain_cnt;
            if (kick) begin
                kick_clr <= clear_kick;
                rd_n     <= rd_num > 32'(DEPTH) ? CW'(DEPTH) : rd_num[CW-1:0];
            end
            if (state == DRAIN && state_n == CLEAR) error <= 1'b0;
            else if (accum_we && !accept) error <= 1'b1;
            s0_v      <= accept;
            s0_addr   <= accum_addr[ADDR_WIDTH-1:0];
            s0_din    <= accum_din;
            s1_v      <= s0_v;
            s1_addr   <= s0_addr;
            s1_din    <= s0_din;
            fwd_hit   <= s0_v && s1_v && s0_addr == s1_addr;
            fwd_sum   <= sum;
            rd_pend   <= issue;
            pend_last <= rd_idx == rd_n - CW'(1);
            rd_idx    <= kick ? '0 : issue ? rd_idx + CW'(1) : rd_idx;
            if (push) begin
                fifo_d[wp] <= ram_q;
                fifo_l[wp] <= pend_last;
                wp         <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_accum_array.sv
// tb_accum_array: directed self-checking bench for accum_array (DEPTH=16)
module tb_accum_array;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] accum_addr = '0;
    logic [63:0] accum_din = '0;
    logic        accum_we = 1'b0;
    logic        clear_kick = 1'b0;
    logic        rd_kick = 1'b0;
    logic [31:0] rd_num = '0;
    logic        busy, error, m_axis_tvalid, m_axis_tlast;
    logic        m_axis_tready = 1'b0;
    logic [63:0] m_axis_tdata;

    int total = 0;
    int passed = 0;
    logic [63:0] exp_val [16];

    typedef struct {
        logic [31:0] addr;
        logic [63:0] din;
        logic        err;
    } upd_t;
    upd_t tbl [11];

    accum_array #(.DEPTH(16), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .accum_addr(accum_addr), .accum_din(accum_din), .accum_we(accum_we),
        .clear_kick(clear_kick), .rd_kick(rd_kick), .rd_num(rd_num),
        .busy(busy), .error(error),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_exp(input logic [63:0] v3, input logic [63:0] v4, input logic [63:0] v5);
        for (int i = 0; i < 16; i++) exp_val[i] = '0;
        exp_val[3] = v3;
        exp_val[4] = v4;
        exp_val[5] = v5;
    endtask

    task automatic count_busy(output int n, output logic saw);
        n = 0;
        saw = 1'b0;
        while (busy && n < 100) begin
            n++;
            if (m_axis_tvalid) saw = 1'b1;
            step();
        end
    endtask

    task automatic readout(input logic [31:0] num, input int nb, input logic [31:0] pat, input string tag);
        int beats, cyc, first, last_c;
        logic held, hl;
        logic [63:0] hd;
        beats = 0; cyc = 0; first = -1; last_c = 0; held = 1'b0; hl = 1'b0; hd = '0;
        rd_num = num;
        rd_kick = 1'b1;
        step();
        rd_kick = 1'b0;
        while ((busy || m_axis_tvalid) && cyc < 200) begin
            m_axis_tready = pat[cyc % 32];
            if (held) begin
                check({tag, "_hold_data"}, m_axis_tdata, hd);
                check({tag, "_hold_vl"}, {m_axis_tvalid, m_axis_tlast}, {1'b1, hl});
            end
            held = m_axis_tvalid && !m_axis_tready;
            hd = m_axis_tdata;
            hl = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                check($sformatf("%s_data%0d", tag, beats), m_axis_tdata, beats < 16 ? exp_val[beats] : 64'hDEAD);
                check($sformatf("%s_last%0d", tag, beats), m_axis_tlast, beats == nb - 1);
                if (first < 0) first = cyc;
                last_c = cyc;
                beats++;
            end
            step();
            cyc++;
        end
        m_axis_tready = 1'b0;
        check({tag, "_done"}, cyc < 200, 1);
        check({tag, "_beats"}, beats, nb);
        if (pat == 32'hFFFF_FFFF && nb > 0) check({tag, "_contig"}, last_c - first, nb - 1);
    endtask

    initial begin
        int n, beats, cyc;
        logic saw;
        tbl[0]  = '{32'd5, 64'd1, 1'b0};
        tbl[1]  = '{32'd5, 64'd2, 1'b0};
        tbl[2]  = '{32'd5, 64'd3, 1'b0};
        tbl[3]  = '{32'd5, 64'd4, 1'b0};
        tbl[4]  = '{32'd3, 64'd1, 1'b0};
        tbl[5]  = '{32'd4, 64'd1, 1'b0};
        tbl[6]  = '{32'd3, 64'd1, 1'b0};
        tbl[7]  = '{32'd4, 64'd1, 1'b0};
        tbl[8]  = '{32'd3, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[9]  = '{32'd16, 64'd7, 1'b1};
        tbl[10] = '{32'h8000_0005, 64'd100, 1'b1};

        step();
        step();
        check("rst_busy", busy, 1);
        check("rst_error", error, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        reset = 1'b1;
        count_busy(n, saw);
        check("init_busy_cycles", n, 16);
        check("init_no_valid", saw, 0);

        set_exp(0, 0, 0);
        readout(16, 16, 32'hFFFF_FFFF, "init");

        for (int i = 0; i < 11; i++) begin
            accum_addr = tbl[i].addr;
            accum_din = tbl[i].din;
            accum_we = 1'b1;
            step();
            check($sformatf("upd%0d_err", i), error, tbl[i].err);
        end
        accum_we = 1'b0;
        step();

        set_exp(1, 2, 10);
        readout(8, 8, 32'hFFFF_FFFF, "rmw");
        readout(6, 6, 32'hAAAA_AAA9, "stall");
        readout(5000, 16, 32'hFFFF_FFFF, "clamp");

        rd_num = 4;
        clear_kick = 1'b1;
        rd_kick = 1'b1;
        step();
        clear_kick = 1'b0;
        rd_kick = 1'b0;
        count_busy(n, saw);
        check("clear_busy_cycles", n, 18);
        check("clear_no_valid", saw, 0);
        check("clear_error", error, 0);
        set_exp(0, 0, 0);
        readout(5000, 16, 32'hFFFF_FFFF, "cleared");

        rd_num = 0;
        rd_kick = 1'b1;
        step();
        rd_kick = 1'b0;
        accum_addr = 2;
        accum_din = 9;
        accum_we = 1'b1;
        step();
        accum_we = 1'b0;
        count_busy(n, saw);
        check("n0_busy_cycles", n + 1, 4);
        check("n0_no_valid", saw, 0);
        check("drain_drop_err", error, 1);
        readout(3, 3, 32'hFFFF_FFFF, "drop");

        rd_num = 16;
        m_axis_tready = 1'b1;
        rd_kick = 1'b1;
        step();
        rd_kick = 1'b0;
        beats = 0;
        cyc = 0;
        while (beats < 3 && cyc < 100) begin
            if (m_axis_tvalid) beats++;
            step();
            cyc++;
        end
        check("mid_beats", beats, 3);
        check("mid_valid_before", m_axis_tvalid, 1);
        reset = 1'b0;
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_tlast", m_axis_tlast, 0);
        m_axis_tready = 1'b0;
        step();
        step();
        reset = 1'b1;
        count_busy(n, saw);
        check("reinit_busy_cycles", n, 16);
        check("reinit_no_valid", saw, 0);
        readout(16, 16, 32'hFFFF_FFFF, "after_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
